// File: rtl/pwm_led_pkg.sv
// pwm_led_pkg: register map and control-bit positions shared by the PWM LED
// slot core and its bench.
package pwm_led_pkg;

    // Slot register indices
    localparam int REG_CTRL      = 0;
    localparam int REG_DIV       = 1;
    localparam int REG_STATUS    = 2;
    localparam int REG_DUTY_BASE = 8;

    // CTRL bit positions
    localparam int CTRL_EN  = 0;
    localparam int CTRL_INV = 1;

    // True when the 5-bit slot address selects register index idx.
    function automatic logic addr_is(input logic [4:0] a, input int idx);
        return a == 5'(idx);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus R-bit period counter.
//   clk, reset : system clock, synchronous active-high reset
//   en         : run enable; when low, pre and cnt are held at 0
//   div        : prescale divisor, one tick every div+1 clocks
//   div_wr     : divisor is being rewritten this cycle; restarts the prescaler
//   tick       : prescaler terminal count (advances cnt)
//   wrap       : tick on the last count of the period (commit point)
//   cnt        : current position within the PWM period
module pwm_timebase #(
    parameter int R = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [15:0]  div,
    input  logic         div_wr,
    output logic         tick,
    output logic         wrap,
    output logic [R-1:0] cnt
);

    logic [15:0] pre;

    assign tick = en & (pre == div);
    assign wrap = tick & (cnt == '1);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            pre <= '0;
            cnt <= '0;
        end else begin
            // A divisor rewrite restarts the prescale interval but leaves the
            // period position alone.
            if (div_wr || tick) pre <= '0;
            else                pre <= pre + 16'd1;
            if (tick) cnt <= cnt + R'(1);
        end
    end

endmodule

// File: rtl/pwm_led_core.sv
// pwm_led_core: MMIO slot core driving W LEDs with independent R-bit PWM.
//   clk, reset : system clock, synchronous active-high reset
//   cs         : slot select
//   read       : read strobe (no side effects; rd_data is combinational)
//   write      : write strobe, qualified by cs
//   addr       : slot register index
//   wr_data    : write data
//   rd_data    : read data, combinational from addr
//   pwm_out    : registered PWM outputs
// Duty writes land in a shadow array and are copied to the active array only
// at a period wrap, so a mid-period write never shortens or stretches a pulse.
module pwm_led_core
    import pwm_led_pkg::*;
#(
    parameter int W = 4,
    parameter int R = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [W-1:0] pwm_out
);

    localparam logic [R:0] FULL = {1'b1, {R{1'b0}}};

    logic [1:0]          ctrl;
    logic [15:0]         div;
    logic [W-1:0][R:0]   shadow;
    logic [W-1:0][R:0]   active;
    logic                pending;
    logic [R-1:0]        cnt;
    logic                tick;
    logic                wrap;
    logic                en;
    logic                inv;
    logic                wr_en;
    logic                div_wr;
    logic                commit;
    logic [R:0]          wr_duty;
    logic [W-1:0]        duty_wr;

    // The read strobe carries no meaning for this slot.
    logic unused_read;
    assign unused_read = read;

    assign en     = ctrl[CTRL_EN];
    assign inv    = ctrl[CTRL_INV];
    assign wr_en  = cs & write;
    assign div_wr = wr_en & addr_is(addr, REG_DIV);
    // wrap already implies tick; the AND keeps the commit qualification visible.
    assign commit = tick & wrap;

    // Clamp on the full 32-bit value so large writes saturate at always-on.
    always_comb begin
        wr_duty = (wr_data > 32'(FULL)) ? FULL : wr_data[R:0];
        for (int k = 0; k < W; k++)
            duty_wr[k] = wr_en & addr_is(addr, REG_DUTY_BASE + k);
    end

    pwm_timebase #(.R(R)) u_timebase (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .div    (div),
        .div_wr (div_wr),
        .tick   (tick),
        .wrap   (wrap),
        .cnt    (cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl <= '0;
            div  <= '0;
        end else begin
            if (wr_en && addr_is(addr, REG_CTRL)) ctrl <= wr_data[1:0];
            if (div_wr)                           div  <= wr_data[15:0];
        end
    end

    // Active loads the pre-write shadow, so a write colliding with a wrap
    // waits for the next wrap and keeps pending set.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            for (int k = 0; k < W; k++) begin
                if (duty_wr[k])      shadow[k] <= wr_duty;
                if (!en || commit)   active[k] <= shadow[k];
            end
            if (!en)              pending <= 1'b0;
            else if (|duty_wr)    pending <= 1'b1;
            else if (commit)      pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out <= '0;
        end else begin
            for (int k = 0; k < W; k++)
                pwm_out[k] <= (en & ({1'b0, cnt} < active[k])) ^ inv;
        end
    end

    always_comb begin
        rd_data = '0;
        if (addr_is(addr, REG_CTRL)) begin
            rd_data[1:0] = ctrl;
        end else if (addr_is(addr, REG_DIV)) begin
            rd_data[15:0] = div;
        end else if (addr_is(addr, REG_STATUS)) begin
            rd_data[0]    = pending;
            rd_data[8+:R] = cnt;
        end
        for (int k = 0; k < W; k++)
            if (addr_is(addr, REG_DUTY_BASE + k)) rd_data[R:0] = shadow[k];
    end

endmodule

// File: tb/tb_pwm_led_core.sv
module tb_pwm_led_core;

    localparam int W = 4;
    localparam int R = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         cs, read, write;
    logic [4:0]   addr;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic [W-1:0] pwm_out;

    pwm_led_core #(.W(W), .R(R)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int hi[W];
    int ri[W];
    int poll_hi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cs = 1'b1; read = 1'b1; addr = a;
        #1;
        d = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    // Count high samples and rising edges per channel over n clocks.
    task automatic measure(input int n);
        logic [W-1:0] prev;
        prev = pwm_out;
        for (int k = 0; k < W; k++) begin hi[k] = 0; ri[k] = 0; end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int k = 0; k < W; k++) begin
                if (pwm_out[k]) hi[k]++;
                if (pwm_out[k] && !prev[k]) ri[k]++;
            end
            prev = pwm_out;
        end
    endtask

    // Poll STATUS until cnt equals target, counting channel-0 high samples.
    task automatic wait_cnt(input int target);
        logic [31:0] s;
        bit hit;
        hit = 1'b0;
        poll_hi = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (pwm_out[0]) poll_hi++;
            rd(5'd2, s);
            if (s[15:8] == 8'(target)) hit = 1'b1;
        end
        if (!hit) begin
            total++; bad++;
            $display("FAIL wait_cnt: got timeout expected cnt=%0d", target);
        end
    endtask

    vec_t vecs[12];
    logic [31:0] got;

    initial begin
        vecs[0]  = '{5'd8,  32'h0000_03FF, 32'd256};
        vecs[1]  = '{5'd9,  32'd256,       32'd256};
        vecs[2]  = '{5'd10, 32'd257,       32'd256};
        vecs[3]  = '{5'd11, 32'h0000_0040, 32'h40};
        vecs[4]  = '{5'd11, 32'hFFFF_FFFF, 32'd256};
        vecs[5]  = '{5'd12, 32'd7,         32'd0};
        vecs[6]  = '{5'd3,  32'h55,        32'd0};
        vecs[7]  = '{5'd2,  32'hFFFF,      32'd0};
        vecs[8]  = '{5'd1,  32'h0001_2345, 32'h2345};
        vecs[9]  = '{5'd0,  32'hFFFF_FFFC, 32'd0};
        vecs[10] = '{5'd0,  32'h2,         32'd2};
        vecs[11] = '{5'd31, 32'd1,         32'd0};

        cs = 0; read = 0; write = 0; addr = 0; wr_data = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset pwm_out", 32'(pwm_out), 32'd0);
        foreach (vecs[i]) begin
            rd(vecs[i].a, got);
            check($sformatf("reset reg %0d", vecs[i].a), got, 32'd0);
        end

        // Register write/readback, clamp, unmapped and read-only addresses
        foreach (vecs[i]) begin
            wr(vecs[i].a, vecs[i].d);
            rd(vecs[i].a, got);
            check($sformatf("reg %0d wr 0x%0h", vecs[i].a, vecs[i].d), got, vecs[i].exp);
        end
        check("disabled inv outputs", 32'(pwm_out), 32'hF);
        wr(5'd0, 32'd0);
        @(negedge clk);
        check("disabled plain outputs", 32'(pwm_out), 32'd0);
        wr(5'd1, 32'd0);

        // Basic duty plus boundary channels
        wr(5'd8, 32'd64); wr(5'd9, 32'd0); wr(5'd10, 32'd256); wr(5'd11, 32'd0);
        wr(5'd0, 32'd1);
        repeat (10) @(negedge clk);
        measure(256);
        check("basic ch0 high", hi[0], 64);
        check("basic ch0 pulses", ri[0], 1);
        check("duty0 ch1 high", hi[1], 0);
        check("duty256 ch2 high", hi[2], 256);

        // Prescaler
        wr(5'd0, 32'd0); wr(5'd1, 32'd3); wr(5'd9, 32'd2); wr(5'd0, 32'd1);
        repeat (10) @(negedge clk);
        measure(1024);
        check("div3 ch1 high", hi[1], 8);
        check("div3 ch1 pulses", ri[1], 1);
        check("div3 ch0 high", hi[0], 256);

        // Double buffering
        wr(5'd0, 32'd0); wr(5'd1, 32'd0); wr(5'd0, 32'd1);
        wait_cnt(100);
        wr(5'd8, 32'd200);
        rd(5'd2, got);
        check("pending after write", got[0], 1);
        wait_cnt(0);
        check("old duty kept this period", poll_hi, 0);
        rd(5'd2, got);
        check("pending after wrap", got[0], 0);
        measure(256);
        check("new duty next period", hi[0], 200);

        // Duty write colliding with wrap
        wait_cnt(254);
        wr(5'd8, 32'd32);
        rd(5'd2, got);
        check("collision status", got, 32'h1);
        rd(5'd8, got);
        check("collision shadow", got, 32'd32);
        measure(128);
        check("collision first half", hi[0], 128);
        rd(5'd2, got);
        check("collision pending mid", got[0], 1);
        measure(128);
        check("collision second half", hi[0], 72);
        rd(5'd2, got);
        check("collision pending cleared", got, 32'd0);
        measure(256);
        check("collision committed duty", hi[0], 32);

        // Inversion, then disable with inversion held
        wr(5'd8, 32'd64); wr(5'd0, 32'd3);
        wait_cnt(0);
        measure(256);
        check("inv ch0 high", hi[0], 192);
        check("inv ch1 high", hi[1], 254);
        check("inv ch2 high", hi[2], 0);
        check("inv ch3 high", hi[3], 256);
        wr(5'd0, 32'd2);
        @(negedge clk);
        check("disable forces inv", 32'(pwm_out), 32'hF);
        rd(5'd2, got);
        check("disable status", got, 32'd0);

        // Reset mid-period
        wr(5'd0, 32'd1); wr(5'd9, 32'd100);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset pwm_out", 32'(pwm_out), 32'd0);
        foreach (vecs[i]) begin
            rd(vecs[i].a, got);
            check($sformatf("mid reset reg %0d", vecs[i].a), got, 32'd0);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post reset idle", 32'(pwm_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_led_core.md
# pwm_led_core

MMIO slot core that drives W LED outputs with independent R-bit pulse-width modulation. It sits directly downstream of the MMIO controller in a slot of the vanilla MMIO subsystem and takes that slot's cs/read/write/addr/wr_data signals. It returns rd_data to the controller and drives `pwm_out` to the board LEDs. Duty updates are double-buffered and commit only at a PWM period boundary, so writes never produce runt pulses.

## Interface
- `W`, 4: number of PWM channels, 1..8
- `R`, 8: duty resolution in bits; period is 2^R prescaler ticks
- `clk` input 1: system clock; the only clock
- `reset` input 1: synchronous, active-high reset
- `cs` input 1: slot select from MMIO controller
- `read` input 1: slot read strobe (qualified by `cs`)
- `write` input 1: slot write strobe (qualified by `cs`)
- `addr` input 5: slot register index
- `wr_data` input 32: write data
- `rd_data` output 32: read data, combinational from `addr`
- `pwm_out` output W: registered PWM outputs to LEDs

## Operation
- Register map, indexed by `addr`:
  - 0 CTRL (R/W): bit0 `en`, bit1 `inv`.
  - 1 DIV (R/W): [15:0] prescale divisor. One tick every DIV+1 clocks.
  - 2 STATUS (RO): bit0 `pending`; [8+R-1:8] current period count `cnt`.
  - 8+k, for k < W, DUTY_k (R/W): [R:0] shadow duty. Reads return the shadow value.
- Unmapped reads return 0. Unmapped or read-only writes are ignored.
- A write takes effect when `cs & write`. `read` has no side effects.
- Shadow duty writes:
  - Values above 2^R are clamped to 2^R on write.
  - 0 means always off; 2^R means always on.
  - Any DUTY write sets `pending`.
- Prescaler: `pre` counts 0..DIV. `tick` is asserted when `pre == DIV`, and `pre` then returns to 0.
- Period counter: `cnt` is R bits and increments on `tick`. It wraps from 2^R-1 to 0.
- Commit: `wrap = tick & (cnt == 2^R-1)`. On `wrap`, every active duty is loaded from its shadow and `pending` clears.
- While `en` = 0:
  - `pre` and `cnt` are held at 0.
  - Active duties track their shadows every cycle.
  - `pending` stays 0.
- Output rule: `pwm_out[k]` <= (`en` & (`cnt` < `active_k`)) ^ `inv`. With `en` = 0, every output sits at `inv`.

## Timing
- Reset values:
  - CTRL, DIV, all shadow and active duties: 0.
  - `pre`, `cnt`, `pending`: 0.
  - `pwm_out`: 0.
- `rd_data` is combinational, valid in the same cycle as `addr`.
- `pwm_out` lags the `cnt` and `active` state by one clock.
- A DIV write resets `pre` to 0 on the next edge. `cnt` is unchanged.
- Writing `en` 0→1 starts counting from `cnt` = 0 in the next cycle.
- Writing `en` 1→0 forces outputs to `inv` one clock later.
- A DUTY write in the same cycle as `wrap`:
  - The active duty takes the old shadow value.
  - The shadow takes the new value.
  - `pending` remains 1.
- Reset asserted mid-period clears all state on the next edge. No commit occurs on that edge.
- High time per period is exactly `active_k` × (DIV+1) clocks. Full period is 2^R × (DIV+1) clocks.

## Structure
- Shared package `pwm_led_pkg`:
  - Register index constants: CTRL=0, DIV=1, STATUS=2, DUTY_BASE=8.
  - CTRL bit positions.
- Sub-module `pwm_timebase`:
  - Contains the prescaler and period counter.
  - Outputs `tick`, `wrap`, `cnt`.
  - Inputs `en`, `div`, `div_wr`.
- The top module holds the register file, shadow/active duty arrays, clamp logic, and the output register.

## Test plan
- Basic duty: R=8, DIV=0, DUTY_0=64, CTRL=1 → `pwm_out[0]` is high for 64 clocks and low for 192, repeating with period 256.
- Prescaler: DIV=3, DUTY_1=2, CTRL=1 → channel 1 is high for 8 clocks per 1024-clock period.
- Double buffering: mid-period write of DUTY_0=200 → STATUS bit0 reads 1; the current period keeps 64; the next period shows 200; STATUS bit0 reads 0 after the wrap.
- Boundary values: DUTY=0 → constant 0. DUTY=256 → constant 1. A write of 0x3FF reads back 256.
- Inversion and disable: CTRL=3 with DUTY=64 → low for 64, high for 192. Then CTRL=2 → all outputs 1 within 1 clock, and STATUS `cnt` reads 0.
- Collision and reset:
  - A DUTY write coincident with `wrap` → active takes the old value, and `pending` stays 1 until the following wrap.
  - `reset` asserted mid-period → all outputs 0 and all registers read 0.
